spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI slave endpoint downstream of the AXI-to-SPI bridge. It consumes SS/SCLK/MOSI from the SPI master and drives MISO back.
- All SPI inputs are oversampled in the ACLK domain. Each complete MSB-first frame is deserialised and pushed into a local receive FIFO, read by the consumer via valid/ready.
- A host-loaded response word is shifted out on MISO during the next frame.
- SPI mode 0 only (CPOL=0, CPHA=0).

Parameters:
- DATA_W, 32, bits per SPI frame.
- SS_INDEX, 0, which SS bit (active-low) selects this slave.
- SS_W, 2, width of the SS bus.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- IDLE_RESP, 32'h0000_0000, word shifted on MISO when no response is loaded.

Ports:
- ACLK  in  1  system clock; must be at least 4x the SCLK frequency.
- ARESET  in  1  synchronous, active-high reset.
- SS  in  SS_W  slave selects from master, active-low, asynchronous to ACLK.
- SCLK  in  1  SPI clock, asynchronous to ACLK.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- rx_data  out  DATA_W  head of the receive FIFO.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- tx_data  in  DATA_W  response word.
- tx_load  in  1  one-cycle strobe: latch tx_data as the pending response.
- busy  out  1  a frame is in progress.
- frame_err  out  1  one-cycle pulse: frame aborted before DATA_W bits.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Input synchronisation
  - SS[SS_INDEX], SCLK and MOSI each pass through a 2-flop synchroniser.
  - Rising and falling SCLK edges are detected from the last two synchronised samples.
  - All internal state acts on the synchronised signals. Edge-to-action latency is 3 ACLK.
- Reset values: MISO=0, rx_valid=0, busy=0, frame_err=0, overflow=0, FIFO empty, pending response = IDLE_RESP, FSM=IDLE.
- FSM states and transitions
  - IDLE: sel falls (SS active) -> load the shift-out register with the pending response (or IDLE_RESP if none). Drive MISO = bit DATA_W-1, clear bit_cnt, go to SHIFT. The pending-valid flag clears on this load.
  - SHIFT, SCLK rising edge: shift-in <= {shift-in[DATA_W-2:0], MOSI}; bit_cnt++.
  - SHIFT, SCLK falling edge with bit_cnt < DATA_W: MISO <= next bit, MSB first.
  - SHIFT, bit_cnt == DATA_W after a rising edge -> go to PUSH.
  - SHIFT, sel rises with bit_cnt < DATA_W -> pulse frame_err, discard data, go to IDLE.
  - PUSH, one cycle: if FIFO not full, write the word; else set overflow and drop the word. Go to WAIT.
  - WAIT: further SCLK edges are ignored. sel rises -> IDLE.
- Outputs
  - busy = 1 in SHIFT, PUSH and WAIT.
  - MISO returns to 0 in IDLE.
- Receive FIFO
  - Registered, first-word fall-through: rx_data is valid whenever rx_valid=1.
  - Push becomes visible on rx_valid the cycle after PUSH.
  - Simultaneous push and pop is allowed, including when the FIFO is full (the pop frees the slot first). Count is unchanged.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from an occupancy counter of log2(FIFO_DEPTH)+1 bits.
- tx_load
  - During a frame, the word is held as pending for the next frame and does not affect the current one.
  - A second tx_load before use overwrites the pending word.
- Overflow: set and ovf_clr in the same cycle -> set wins.
- ARESET mid-frame: everything returns to reset values immediately. The partially received word is lost. If SS is still asserted, no frame starts until sel is seen high and then falls again (IDLE requires a falling edge).
- SS bits other than SS_INDEX are ignored.

Decomposition:
- Package spi_pkg holds:
  - typedef spi_state_e {IDLE, SHIFT, PUSH, WAIT};
  - the default DATA_W and IDLE_RESP constants, shared with the master side.
- One natural sub-module: sync_fifo (the parameterised FWFT receive FIFO with occupancy counter). It is reusable in place of the existing counter FIFO.
- The synchroniser and edge detect stay inline.

Test Plan:
- Mode-0 frame 0xA5A5_1234 on SS[0], SCLK = ACLK/8 -> rx_valid rises 1 cycle after PUSH with rx_data=0xA5A5_1234. frame_err=0, busy falls after SS rises.
- tx_load 0xDEAD_BEEF, then a frame of 0x0 -> MISO sampled on SCLK rising edges reads 0xDEAD_BEEF. The next frame with no load returns IDLE_RESP.
- Five back-to-back frames (0x1..0x5) with rx_ready=0, FIFO_DEPTH=4 -> FIFO holds 0x1..0x4 and overflow=1. Pop all -> 0x1..0x4 in order. ovf_clr -> overflow=0.
- SS deasserted after 10 bits -> one-cycle frame_err, FIFO unchanged. The following full frame 0x0F0F_0F0F is received correctly.
- Frame on SS[1] only -> no rx_valid, MISO stays 0, busy=0.
- ARESET asserted at bit 16 while SS stays low -> all outputs at reset values, no push. After SS toggles high then low, a new frame 0x1234_5678 is received.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants and the slave FSM state encoding.
// Also intended for use by the master side of the bridge.
package spi_pkg;

    localparam int unsigned SPI_DATA_W    = 32;
    localparam logic [31:0] SPI_IDLE_RESP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2,
        WAIT  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the host-side receive/response signals of the SPI slave endpoint.
interface spi_slave_rx_if #(
    parameter int unsigned DATA_W = spi_pkg::SPI_DATA_W,
    parameter int unsigned SS_W   = 2
);
    logic [SS_W-1:0]   SS;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              busy;
    logic              frame_err;
    logic              overflow;
    logic              ovf_clr;

    modport slave (
        input  SS, SCLK, MOSI, rx_ready, tx_data, tx_load, ovf_clr,
        output MISO, rx_data, rx_valid, busy, frame_err, overflow
    );

    modport master (
        output SS, SCLK, MOSI, rx_ready, tx_data, tx_load, ovf_clr,
        input  MISO, rx_data, rx_valid, busy, frame_err, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with an occupancy counter.
// A pop in the same cycle frees the slot for a push to a full FIFO.
module sync_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop_c  = rd_en_i & ~empty_o;
        do_push_c = wr_en_i & (~full_o | do_pop_c);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversamples SS/SCLK/MOSI in ACLK, deserialises MSB-first
// frames into a receive FIFO and shifts a host-loaded response out on MISO.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W     = SPI_DATA_W,
    parameter int unsigned       SS_INDEX   = 0,
    parameter int unsigned       SS_W       = 2,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_RESP  = DATA_W'(SPI_IDLE_RESP)
) (
    input logic            ACLK,
    input logic            ARESET,
    spi_slave_rx_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    spi_state_e state_q, state_d;

    logic              ss_meta_q, ss_sync_q, ss_prev_q;
    logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic              mosi_meta_q, mosi_sync_q;
    logic              ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;

    logic [DATA_W-1:0] shift_in_q, shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] resp_c;

    logic              push_c;
    logic              pop_c;
    logic              ovf_set_c;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              unused_ss;

    assign unused_ss = ^bus.SS;

    // Synchronisers reset to "selected" so an SS held low across reset
    // cannot masquerade as a fresh falling edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_prev_q   <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= bus.SS[SS_INDEX];
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sclk_meta_q <= bus.SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= bus.MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign ss_fall_c   =  ss_prev_q   & ~ss_sync_q;
    assign ss_rise_c   = ~ss_prev_q   &  ss_sync_q;
    assign sclk_rise_c = ~sclk_prev_q &  sclk_sync_q;
    assign sclk_fall_c =  sclk_prev_q & ~sclk_sync_q;
    assign resp_c      = pend_vld_q ? pend_q : IDLE_RESP;

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (ss_fall_c) state_d = SHIFT;
            SHIFT: begin
                if (ss_rise_c) begin
                    state_d = IDLE;
                end else if (sclk_rise_c && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PUSH;
                end
            end
            PUSH:  state_d = WAIT;
            // Level test so a deselect that lands during PUSH is not missed.
            WAIT:  if (ss_sync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        bit_cnt_d   = bit_cnt_q;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall_c) begin
                    shift_in_d  = '0;
                    shift_out_d = resp_c;
                    miso_d      = resp_c[DATA_W-1];
                    bit_cnt_d   = '0;
                    pend_vld_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_rise_c) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    bit_cnt_d   = '0;
                end else if (sclk_rise_c) begin
                    shift_in_d = {shift_in_q[DATA_W-2:0], mosi_sync_q};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end else if (sclk_fall_c && bit_cnt_q < CNT_W'(DATA_W)) begin
                    shift_out_d = shift_out_q << 1;
                    miso_d      = shift_out_q[DATA_W-2];
                end
            end
            PUSH: push_c = 1'b1;
            WAIT: if (ss_sync_q) miso_d = 1'b0;
            default: miso_d = 1'b0;
        endcase
        // A load always targets the next frame, never the one in flight.
        if (bus.tx_load) begin
            pend_d     = bus.tx_data;
            pend_vld_d = 1'b1;
        end
        pop_c      = bus.rx_ready & ~fifo_empty;
        ovf_set_c  = push_c & fifo_full & ~pop_c;
        overflow_d = ovf_set_c ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            shift_in_q  <= '0;
            shift_out_q <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= IDLE_RESP;
            pend_vld_q  <= 1'b0;
        end else begin
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .wr_en_i   (push_c),
        .wr_data_i (shift_in_q),
        .rd_en_i   (bus.rx_ready),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign bus.MISO      = miso_q;
    assign bus.rx_data   = fifo_rd_data;
    assign bus.rx_valid  = ~fifo_empty;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: mode-0 frames at SCLK = ACLK/8, response
// shifting, FIFO overflow, aborted frames, foreign selects and mid-frame reset.
module tb_spi_slave_rx;
    logic ACLK;
    logic ARESET;

    spi_slave_rx_if #(.DATA_W(32), .SS_W(2)) bus ();

    spi_slave_rx #(
        .DATA_W     (32),
        .SS_INDEX   (0),
        .SS_W       (2),
        .FIFO_DEPTH (4),
        .IDLE_RESP  (32'h0000_0000)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) begin
        if (!ARESET) begin
            if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
            if (bus.busy)      busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic select(input logic [1:0] ss);
        bus.SS = ss;
        wait_clks(8);
    endtask

    task automatic deselect();
        bus.SS = 2'b11;
        wait_clks(8);
    endtask

    // Mode 0: master drives MOSI while SCLK low, both sides sample on the rise.
    task automatic send_bits(input logic [31:0] w, input int n, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            bus.MOSI = w[31-i];
            wait_clks(4);
            bus.SCLK = 1'b1;
            r = {r[30:0], bus.MISO};
            wait_clks(4);
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] w, output logic [31:0] r);
        select(2'b10);
        send_bits(w, 32, r);
        deselect();
    endtask

    task automatic pop();
        bus.rx_ready = 1'b1;
        wait_clks(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic load_tx(input logic [31:0] w);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        wait_clks(1);
        bus.tx_load = 1'b0;
    endtask

    logic [31:0] miso_word;
    int          ferr_before;
    int          busy_before;

    initial begin
        bus.SS = 2'b11; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        bus.rx_ready = 1'b0; bus.tx_data = '0; bus.tx_load = 1'b0; bus.ovf_clr = 1'b0;
        ARESET = 1'b1;
        wait_clks(3);
        ARESET = 1'b0;
        wait_clks(4);
        check_eq("rst_miso", 32'(bus.MISO), 32'd0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);

        // Basic frame
        ferr_before = ferr_cnt;
        select(2'b10);
        check_eq("f1_busy_start", 32'(bus.busy), 32'd1);
        send_bits(32'hA5A5_1234, 32, miso_word);
        wait_clks(2);
        check_eq("f1_valid", 32'(bus.rx_valid), 32'd1);
        check_eq("f1_data", bus.rx_data, 32'hA5A5_1234);
        check_eq("f1_busy_held", 32'(bus.busy), 32'd1);
        check_eq("f1_miso_idle", miso_word, 32'h0000_0000);
        deselect();
        check_eq("f1_busy_end", 32'(bus.busy), 32'd0);
        check_eq("f1_no_err", 32'(ferr_cnt - ferr_before), 32'd0);
        pop();
        check_eq("f1_popped", 32'(bus.rx_valid), 32'd0);

        // Response word, then fallback to idle response
        load_tx(32'hDEAD_BEEF);
        frame(32'h0, miso_word);
        check_eq("tx_miso", miso_word, 32'hDEAD_BEEF);
        check_eq("tx_rx_zero", bus.rx_data, 32'h0);
        pop();
        frame(32'h0, miso_word);
        check_eq("tx_miso_idle", miso_word, 32'h0000_0000);
        pop();

        // Overflow on the fifth queued frame
        for (int k = 1; k <= 5; k++) begin
            frame(32'(k), miso_word);
            if (k == 4) check_eq("ovf_not_yet", 32'(bus.overflow), 32'd0);
        end
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check_eq("ovf_pop_valid", 32'(bus.rx_valid), 32'd1);
            check_eq("ovf_pop_data", bus.rx_data, 32'(k));
            pop();
        end
        check_eq("ovf_empty", 32'(bus.rx_valid), 32'd0);
        check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        wait_clks(1);
        bus.ovf_clr = 1'b0;
        wait_clks(1);
        check_eq("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Aborted frame after 10 bits
        ferr_before = ferr_cnt;
        select(2'b10);
        send_bits(32'hFFFF_FFFF, 10, miso_word);
        deselect();
        check_eq("abort_err_pulses", 32'(ferr_cnt - ferr_before), 32'd1);
        check_eq("abort_no_push", 32'(bus.rx_valid), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        frame(32'h0F0F_0F0F, miso_word);
        check_eq("after_abort_valid", 32'(bus.rx_valid), 32'd1);
        check_eq("after_abort_data", bus.rx_data, 32'h0F0F_0F0F);
        pop();

        // Frame addressed to the other slave
        load_tx(32'hFFFF_FFFF);
        busy_before = busy_cnt;
        select(2'b01);
        send_bits(32'h1357_9BDF, 32, miso_word);
        deselect();
        check_eq("ss1_miso", miso_word, 32'h0);
        check_eq("ss1_busy", 32'(busy_cnt - busy_before), 32'd0);
        check_eq("ss1_valid", 32'(bus.rx_valid), 32'd0);

        // Reset in the middle of a frame with SS still low
        select(2'b10);
        send_bits(32'hCAFE_F00D, 16, miso_word);
        ARESET = 1'b1;
        wait_clks(2);
        ARESET = 1'b0;
        wait_clks(1);
        check_eq("mrst_miso", 32'(bus.MISO), 32'd0);
        check_eq("mrst_busy", 32'(bus.busy), 32'd0);
        check_eq("mrst_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("mrst_overflow", 32'(bus.overflow), 32'd0);
        busy_before = busy_cnt;
        send_bits(32'hFFFF_FFFF, 16, miso_word);
        check_eq("mrst_no_restart", 32'(busy_cnt - busy_before), 32'd0);
        check_eq("mrst_no_push", 32'(bus.rx_valid), 32'd0);
        deselect();
        frame(32'h1234_5678, miso_word);
        check_eq("mrst_new_valid", 32'(bus.rx_valid), 32'd1);
        check_eq("mrst_new_data", bus.rx_data, 32'h1234_5678);
        check_eq("mrst_pending_lost", miso_word, 32'h0);
        pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
